tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single byte-serial transmitter among `N_REQ` requesters. It grants one requester at a time and presents that requester's word to the transmitter. It also drives the transmitter's enable (`connection_status`) for exactly one frame and acknowledges the requester. It sits between the requester-side logic and the transmitter, and owns all sequencing of the serial line.

---
 rtl/tx_sched_pkg.sv | 15 +
 rtl/tx_scheduler_if.sv | 25 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/tx_scheduler.sv | 139 +++++++++++++
 tb/tb_tx_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the round-robin transmit scheduler.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StSend,
        StGap
    } state_e;

    localparam int unsigned DefFrameLen = 9;
    localparam int unsigned DefGapLen   = 1;
    localparam int unsigned CntW        = 4;

endpackage

// File: rtl/tx_scheduler_if.sv
// Requester-side and transmitter-side handshake bundle for tx_scheduler.
interface tx_scheduler_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WORD_W = 8
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*WORD_W-1:0] req_word;
    logic [N_REQ-1:0]        req_ack;
    logic                    tx_ready;
    logic [WORD_W-1:0]       tx_word;
    logic                    tx_en;

    // master: the scheduler; slave: requesters plus transmitter
    modport master (
        input  req_valid, req_word, tx_ready,
        output req_ack, tx_word, tx_en
    );

    modport slave (
        output req_valid, req_word, tx_ready,
        input  req_ack, tx_word, tx_en
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: search starts one past the last grant.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any
);

    localparam int unsigned IdW = $clog2(N_REQ);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (!any && req_valid[IdW'(idx)]) begin
                any    = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one byte-serial transmitter among N_REQ requesters.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned GAP_LEN   = DefGapLen
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     link_up,
    tx_scheduler_if.master           bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     abort
);

    localparam int unsigned IdW = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   gcnt_q, gcnt_d;
    logic [IdW-1:0]    grant_q, grant_d;
    logic [IdW-1:0]    last_q, last_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;

    logic [IdW-1:0]    winner;
    logic              any_req;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (last_q),
        .winner     (winner),
        .any        (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        word_d  = word_q;
        ack_d   = '0;
        en_d    = en_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                en_d = 1'b0;
                if (link_up && any_req) begin
                    grant_d = winner;
                    word_d  = bus.req_word[32'(winner) * WORD_W +: WORD_W];
                    state_d = StArm;
                end
            end
            StArm: begin
                // Losing the link before the ack leaves last_grant alone so the requester retries
                if (!link_up) begin
                    state_d = StIdle;
                end else if (bus.tx_ready) begin
                    ack_d[grant_q] = 1'b1;
                    en_d           = 1'b1;
                    cnt_d          = '0;
                    state_d        = StSend;
                end
            end
            StSend: begin
                if (!link_up) begin
                    en_d    = 1'b0;
                    abort_d = 1'b1;
                    last_d  = grant_q;
                    gcnt_d  = '0;
                    state_d = StGap;
                end else if (cnt_q == CntW'(FRAME_LEN - 1)) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    last_d  = grant_q;
                    gcnt_d  = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                en_d = 1'b0;
                if (gcnt_q == CntW'(GAP_LEN - 1)) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            grant_q <= '0;
            last_q  <= IdW'(N_REQ - 1);
            word_q  <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            word_q  <= word_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.req_ack = ack_q;
    assign bus.tx_word = word_q;
    assign bus.tx_en   = en_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != StIdle);
    assign frame_done  = done_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: per-cycle vector table plus multi-cycle corner sequences.
module tb_tx_scheduler;

    localparam int unsigned FrameLen = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_up;
    logic [1:0] grant_id;
    logic       busy;
    logic       frame_done;
    logic       abort;

    int checks = 0;
    int errors = 0;

    logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

    tx_scheduler_if #(.N_REQ(4), .WORD_W(8)) bus ();

    tx_scheduler #(
        .N_REQ     (4),
        .WORD_W    (8),
        .FRAME_LEN (FrameLen),
        .GAP_LEN   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link_up    (link_up),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       link;
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] ack;
        logic       en;
        logic       fd;
        logic       ab;
        logic [1:0] gid;
        logic       busy;
        logic [7:0] word;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic link, input logic [3:0] valid, input logic rdy,
                                input logic [3:0] ack, input logic en, input logic fd,
                                input logic ab, input logic [1:0] gid, input logic bsy,
                                input logic [7:0] word);
        vec_t v;
        v.link = link; v.valid = valid; v.rdy = rdy; v.ack = ack; v.en = en;
        v.fd = fd; v.ab = ab; v.gid = gid; v.busy = bsy; v.word = word;
        return v;
    endfunction

    // One complete frame for requester id, with `stall` ARM cycles of tx_ready low
    task automatic add_frame(input int id, input int stall);
        logic [3:0] v;
        logic [1:0] g;
        v = 4'b0001 << id;
        g = 2'(id);
        vecs.push_back(mk(1'b1, v, stall == 0, 4'b0, 1'b0, 1'b0, 1'b0, g, 1'b1, words[id]));
        for (int i = 0; i < stall; i++)
            vecs.push_back(mk(1'b1, v, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, g, 1'b1, words[id]));
        vecs.push_back(mk(1'b1, v, 1'b1, v, 1'b1, 1'b0, 1'b0, g, 1'b1, words[id]));
        for (int i = 0; i < FrameLen - 1; i++)
            vecs.push_back(mk(1'b1, 4'b0, 1'b1, 4'b0, 1'b1, 1'b0, 1'b0, g, 1'b1, words[id]));
        vecs.push_back(mk(1'b1, 4'b0, 1'b1, 4'b0, 1'b0, 1'b1, 1'b0, g, 1'b1, words[id]));
        vecs.push_back(mk(1'b1, 4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0, g, 1'b0, words[id]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {bus.req_ack, bus.tx_en, frame_done, abort, grant_id, busy, bus.tx_word};
    endfunction

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int n;
        int last_c;

        rst           = 1'b0;
        link_up       = 1'b1;
        bus.req_valid = 4'b0;
        bus.tx_ready  = 1'b1;
        bus.req_word  = {words[3], words[2], words[1], words[0]};
        step();
        step();
        check("reset_state", 64'(outs()), 64'd0);
        rst = 1'b1;

        // Single request, ARM stall, and rotation across non-adjacent requesters
        add_frame(0, 0);
        add_frame(1, 5);
        add_frame(3, 0);
        add_frame(2, 0);
        foreach (vecs[i]) begin
            link_up       = vecs[i].link;
            bus.req_valid = vecs[i].valid;
            bus.tx_ready  = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vecs[i].ack, vecs[i].en, vecs[i].fd, vecs[i].ab, vecs[i].gid,
                       vecs[i].busy, vecs[i].word}));
        end

        // Reset in the middle of a frame for requester 3
        bus.req_valid = 4'b1000;
        bus.tx_ready  = 1'b1;
        step();
        step();
        check("mid_ack", 64'(bus.req_ack), 64'h8);
        bus.req_valid = 4'b0;
        step();
        step();
        step();
        check("mid_en", 64'(bus.tx_en), 64'd1);
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        step();
        check("mid_reset", 64'(outs()), 64'd0);
        rst = 1'b1;
        step();
        check("post_reset_grant", 64'({grant_id, busy}), 64'({2'd0, 1'b1}));

        // All four requesting continuously: 0,1,2,3,0 every 12 cycles
        n      = 0;
        last_c = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            step();
            if (bus.req_ack != 4'b0) begin
                check($sformatf("rr_ack%0d", n), 64'(bus.req_ack), 64'(4'b0001 << order[n]));
                check($sformatf("rr_word%0d", n), 64'(bus.tx_word), 64'(words[order[n]]));
                if (n > 0) check($sformatf("rr_period%0d", n), 64'(c - last_c), 64'd12);
                last_c = c;
                n++;
            end
        end
        check("rr_count", 64'(n), 64'd5);
        bus.req_valid = 4'b0;
        wait_idle("rr_idle");

        // Link drop during SEND cycle 4 of requester 1
        bus.req_valid = 4'b0010;
        step();
        step();
        check("ab_ack", 64'(bus.req_ack), 64'h2);
        bus.req_valid = 4'b0;
        step();
        step();
        step();
        link_up = 1'b0;
        step();
        check("ab_pulse", 64'({bus.tx_en, abort, frame_done, busy}), 64'b0101);
        step();
        check("ab_gap_end", 64'({abort, busy}), 64'd0);
        bus.req_valid = 4'b0110;
        step();
        check("link_block", 64'(busy), 64'd0);
        link_up = 1'b1;
        step();
        check("ab_next_grant", 64'({grant_id, busy}), 64'({2'd2, 1'b1}));
        step();
        check("ab_next_ack", 64'(bus.req_ack), 64'h4);
        bus.req_valid = 4'b0;
        wait_idle("ab_idle");

        // Link drop while waiting in ARM: no ack, same requester retried
        bus.req_valid = 4'b1000;
        bus.tx_ready  = 1'b0;
        step();
        check("arm_grant", 64'({grant_id, busy}), 64'({2'd3, 1'b1}));
        link_up = 1'b0;
        step();
        check("arm_drop", 64'({bus.req_ack, bus.tx_en, busy}), 64'd0);
        step();
        check("arm_hold_idle", 64'(busy), 64'd0);
        link_up       = 1'b1;
        bus.req_valid = 4'b1001;
        bus.tx_ready  = 1'b1;
        step();
        check("arm_regrant", 64'({grant_id, busy}), 64'({2'd3, 1'b1}));
        step();
        check("arm_ack", 64'(bus.req_ack), 64'h8);
        bus.req_valid = 4'b0;
        wait_idle("arm_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
